// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register port: FSM encoding, ACK levels,
// default bus address and pointer arithmetic.
package i2c_pkg;

  typedef enum logic [3:0] {
    s_IDLE,
    s_ADDR,
    s_ADDR_ACK,
    s_REG,
    s_REG_ACK,
    s_WRITE,
    s_WRITE_ACK,
    s_READ,
    s_READ_ACK
  } i2c_state_t;

  localparam logic       I2C_ACK             = 1'b0;
  localparam logic       I2C_NACK            = 1'b1;
  localparam logic [6:0] I2C_DEFAULT_ADDRESS = 7'h50;
  localparam logic [3:0] I2C_BYTE_BITS       = 4'd8;

  // Register pointer wraps 8'hFF -> 8'h00
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr);
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Oversamples SCL/SDA into i_clk and flags bus events three cycles after a pin change.
// o_sdaSync is aligned with the event flags so it holds the bit value at an sclRise.
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sclRise,
  output logic o_sclFall,
  output logic o_start,
  output logic o_stop,
  output logic o_sdaSync
);

  logic r_sclMeta, r_sclSync, r_sclPrev;
  logic r_sdaMeta, r_sdaSync, r_sdaPrev;
  logic r_sclRise, r_sclFall, r_start, r_stop;

  // Synchronizers reset to the idle-high bus level so release never fakes an event
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclMeta <= 1'b1;
      r_sclSync <= 1'b1;
      r_sclPrev <= 1'b1;
      r_sdaMeta <= 1'b1;
      r_sdaSync <= 1'b1;
      r_sdaPrev <= 1'b1;
      r_sclRise <= 1'b0;
      r_sclFall <= 1'b0;
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
    end else begin
      r_sclMeta <= i_scl;
      r_sclSync <= r_sclMeta;
      r_sclPrev <= r_sclSync;
      r_sdaMeta <= i_sda;
      r_sdaSync <= r_sdaMeta;
      r_sdaPrev <= r_sdaSync;
      r_sclRise <= r_sclSync & ~r_sclPrev;
      r_sclFall <= ~r_sclSync & r_sclPrev;
      r_start   <= r_sclSync & r_sclPrev & r_sdaPrev & ~r_sdaSync;
      r_stop    <= r_sclSync & r_sclPrev & ~r_sdaPrev & r_sdaSync;
    end
  end

  assign o_sclRise = r_sclRise;
  assign o_sclFall = r_sclFall;
  assign o_start   = r_start;
  assign o_stop    = r_stop;
  assign o_sdaSync = r_sdaPrev;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target giving an external controller byte access to the register file through
// an auto-incrementing 8-bit pointer. SDA is open-drain; SCL is never stretched.
//
// state        | meaning
// s_IDLE       | SDA released, waiting for START
// s_ADDR       | shifting in address + R/W
// s_ADDR_ACK   | driving address ACK; read fetch on its closing fall
// s_REG        | shifting in register pointer
// s_REG_ACK    | driving pointer ACK
// s_WRITE      | shifting in write data
// s_WRITE_ACK  | driving data ACK after the write strobe
// s_READ       | shifting out read data
// s_READ_ACK   | sampling controller ACK/NACK
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = I2C_DEFAULT_ADDRESS
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] o_regAddress,
  output logic [7:0] o_regWriteData,
  output logic       o_regWriteStrobe,
  input  logic [7:0] i_regReadData,
  output logic       o_regReadStrobe,
  output logic       o_busy
);

  logic w_sclRise, w_sclFall, w_start, w_stop, w_sdaSync;

  i2c_bus_sync u_bus_sync (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_scl     (i2c_scl),
    .i_sda     (i2c_sda),
    .o_sclRise (w_sclRise),
    .o_sclFall (w_sclFall),
    .o_start   (w_start),
    .o_stop    (w_stop),
    .o_sdaSync (w_sdaSync)
  );

  i2c_state_t r_state, w_state;
  logic [3:0] r_bitCnt, w_bitCnt;
  logic [7:0] r_shift, w_shift;
  logic [7:0] r_regAddress, w_regAddress;
  logic [7:0] r_wdata, w_wdata;
  logic       r_sdaLow, w_sdaLow;
  logic       r_wstrobe, w_wstrobe;
  logic       r_incPend, w_incPend;
  logic       r_busy, w_busy;
  logic       w_rstrobe;
  logic       w_sdaOe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= s_IDLE;
      r_bitCnt     <= 4'd0;
      r_shift      <= 8'h00;
      r_regAddress <= 8'h00;
      r_wdata      <= 8'h00;
      r_sdaLow     <= 1'b0;
      r_wstrobe    <= 1'b0;
      r_incPend    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_bitCnt     <= w_bitCnt;
      r_shift      <= w_shift;
      r_regAddress <= w_regAddress;
      r_wdata      <= w_wdata;
      r_sdaLow     <= w_sdaLow;
      r_wstrobe    <= w_wstrobe;
      r_incPend    <= w_incPend;
      r_busy       <= w_busy;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_bitCnt     = r_bitCnt;
    w_shift      = r_shift;
    w_regAddress = r_incPend ? ptr_inc(r_regAddress) : r_regAddress;
    w_wdata      = r_wdata;
    w_sdaLow     = r_sdaLow;
    w_wstrobe    = 1'b0;
    w_rstrobe    = 1'b0;
    w_incPend    = 1'b0;
    w_busy       = r_busy;

    if (w_start) begin
      w_state  = s_ADDR;
      w_bitCnt = 4'd0;
      w_sdaLow = 1'b0;
    end else if (w_stop) begin
      w_state  = s_IDLE;
      w_bitCnt = 4'd0;
      w_sdaLow = 1'b0;
      w_busy   = 1'b0;
    end else begin
      unique case (r_state)
        s_IDLE: w_sdaLow = 1'b0;

        s_ADDR, s_REG, s_WRITE: begin
          if (w_sclRise && r_bitCnt < I2C_BYTE_BITS) begin
            w_shift  = {r_shift[6:0], w_sdaSync};
            w_bitCnt = r_bitCnt + 4'd1;
          end else if (w_sclFall && r_bitCnt == I2C_BYTE_BITS) begin
            w_bitCnt = 4'd0;
            w_sdaLow = 1'b1;
            if (r_state == s_ADDR) begin
              if (r_shift[7:1] == I2C_ADDRESS) begin
                w_state = s_ADDR_ACK;
                w_busy  = 1'b1;
              end else begin
                w_state  = s_IDLE;
                w_sdaLow = 1'b0;
                w_busy   = 1'b0;
              end
            end else if (r_state == s_REG) begin
              w_regAddress = r_shift;
              w_state      = s_REG_ACK;
            end else begin
              w_wdata   = r_shift;
              w_wstrobe = 1'b1;
              w_incPend = 1'b1;
              w_state   = s_WRITE_ACK;
            end
          end
        end

        s_ADDR_ACK: begin
          if (w_sclFall) begin
            w_bitCnt = 4'd0;
            if (r_shift[0] == 1'b0) begin
              w_state  = s_REG;
              w_sdaLow = 1'b0;
            end else begin
              w_state   = s_READ;
              w_shift   = i_regReadData;
              w_rstrobe = 1'b1;
              w_sdaLow  = ~i_regReadData[7];
            end
          end
        end

        s_REG_ACK, s_WRITE_ACK: begin
          if (w_sclFall) begin
            w_state  = s_WRITE;
            w_bitCnt = 4'd0;
            w_sdaLow = 1'b0;
          end
        end

        s_READ: begin
          if (w_sclRise && r_bitCnt < I2C_BYTE_BITS) begin
            w_bitCnt = r_bitCnt + 4'd1;
          end else if (w_sclFall && r_bitCnt == I2C_BYTE_BITS) begin
            w_state      = s_READ_ACK;
            w_bitCnt     = 4'd0;
            w_sdaLow     = 1'b0;
            w_regAddress = ptr_inc(r_regAddress);
          end else if (w_sclFall && r_bitCnt != 4'd0) begin
            w_shift  = {r_shift[6:0], 1'b0};
            w_sdaLow = ~r_shift[6];
          end
        end

        s_READ_ACK: begin
          // bitCnt == 1 marks that the controller acknowledged the byte
          if (w_sclRise) begin
            if (w_sdaSync == I2C_NACK) begin
              w_state = s_IDLE;
              w_busy  = 1'b0;
            end else begin
              w_bitCnt = 4'd1;
            end
          end else if (w_sclFall && r_bitCnt == 4'd1) begin
            w_state   = s_READ;
            w_bitCnt  = 4'd0;
            w_shift   = i_regReadData;
            w_rstrobe = 1'b1;
            w_sdaLow  = ~i_regReadData[7];
          end
        end

        default: begin
          w_state  = s_IDLE;
          w_sdaLow = 1'b0;
        end
      endcase
    end
  end

  // Enable decoded from reset-cleared state so reset releases SDA at once
  assign w_sdaOe = r_sdaLow && (r_state != s_IDLE);
  assign i2c_sda = w_sdaOe ? I2C_ACK : 1'bz;

  assign o_regAddress     = r_regAddress;
  assign o_regWriteData   = r_wdata;
  assign o_regWriteStrobe = r_wstrobe;
  assign o_regReadStrobe  = w_rstrobe;
  assign o_busy           = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, stub register file, and a
// reference memory/strobe list built from the transactions the bench issues.
module tb_i2c_target_regs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr, wdata, rdata;
  logic       wstb, rstb, busy;

  pullup (sda_bus);
  assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;

  i2c_target_regs dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i2c_scl          (scl),
    .i2c_sda          (sda_bus),
    .o_regAddress     (reg_addr),
    .o_regWriteData   (wdata),
    .o_regWriteStrobe (wstb),
    .i_regReadData    (rdata),
    .o_regReadStrobe  (rstb),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  logic [7:0]  regfile [256];
  logic        rf_init = 1'b0;
  logic [15:0] wq[$];
  logic [7:0]  rq[$];

  assign rdata = regfile[reg_addr];

  // Stub register file plus strobe logging
  always @(negedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 256; i++) regfile[i] = 8'(i) ^ 8'hFF;
      rf_init = 1'b1;
    end
    if (wstb) begin
      wq.push_back({reg_addr, wdata});
      regfile[reg_addr] = wdata;
    end
    if (rstb) rq.push_back(reg_addr);
  end

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_wq[$];
  logic [7:0]  exp_rq[$];
  logic [7:0]  txq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qtr();
    repeat (10) @(posedge clk);
  endtask

  task automatic half();
    repeat (20) @(posedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_drv_low = ~b;
    qtr();
    scl = 1'b1;
    qtr();
    s = sda_bus;
    qtr();
    scl = 1'b0;
    qtr();
  endtask

  task automatic bus_start();
    sda_drv_low = 1'b0;
    qtr();
    scl = 1'b1;
    half();
    sda_drv_low = 1'b1;
    half();
    scl = 1'b0;
    qtr();
  endtask

  task automatic bus_stop();
    sda_drv_low = 1'b1;
    qtr();
    scl = 1'b1;
    half();
    sda_drv_low = 1'b0;
    half();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic s;
    for (int i = 0; i < n; i++) clk_bit(b[7-i], s);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d[7-i] = s;
    end
    clk_bit(nack, s);
  endtask

  task automatic check_wq(input string tag);
    chk({tag, "_wcount"}, wq.size(), exp_wq.size());
    if (wq.size() == exp_wq.size())
      for (int i = 0; i < wq.size(); i++) chk({tag, "_wstrobe"}, wq[i], exp_wq[i]);
    wq.delete();
    exp_wq.delete();
  endtask

  task automatic check_rq(input string tag);
    chk({tag, "_rcount"}, rq.size(), exp_rq.size());
    if (rq.size() == exp_rq.size())
      for (int i = 0; i < rq.size(); i++) chk({tag, "_rstrobe"}, rq[i], exp_rq[i]);
    rq.delete();
    exp_rq.delete();
  endtask

  task automatic write_txn(input logic [7:0] ptr, input string tag);
    logic ack;
    bus_start();
    write_byte(8'hA0, ack);
    chk({tag, "_ack_addr"}, ack, 0);
    chk({tag, "_busy"}, busy, 1);
    write_byte(ptr, ack);
    chk({tag, "_ack_ptr"}, ack, 0);
    for (int i = 0; i < txq.size(); i++) begin
      write_byte(txq[i], ack);
      chk({tag, "_ack_data"}, ack, 0);
      ref_mem[8'(ptr + i)] = txq[i];
      exp_wq.push_back({8'(ptr + i), txq[i]});
    end
    bus_stop();
    chk({tag, "_busy_after_stop"}, busy, 0);
    check_wq(tag);
    txq.delete();
  endtask

  task automatic read_txn(input logic [7:0] ptr, input int n, input string tag);
    logic ack;
    logic [7:0] d;
    bus_start();
    write_byte(8'hA0, ack);
    chk({tag, "_ack_addr"}, ack, 0);
    write_byte(ptr, ack);
    chk({tag, "_ack_ptr"}, ack, 0);
    bus_start();
    write_byte(8'hA1, ack);
    chk({tag, "_ack_raddr"}, ack, 0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, d);
      chk({tag, "_rdata"}, d, ref_mem[8'(ptr + i)]);
      exp_rq.push_back(8'(ptr + i));
    end
    chk({tag, "_sda_released"}, sda_bus, 1);
    chk({tag, "_busy_after_nack"}, busy, 0);
    bus_stop();
    check_rq(tag);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic s;
    logic all_high;
    logic [7:0] ptr;
    int n;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hFF;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_addr", reg_addr, 8'h00);
    chk("reset_wdata", wdata, 8'h00);
    chk("reset_strobes", {wstb, rstb}, 2'b00);
    chk("reset_busy", busy, 0);
    chk("reset_sda", sda_bus, 1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // basic write
    txq = '{8'h5A, 8'hC3};
    write_txn(8'h10, "write");
    chk("write_ptr_after", reg_addr, 8'h12);

    // read with repeated START
    read_txn(8'h20, 2, "read");

    // address mismatch
    bus_start();
    write_byte(8'hA2, ack);
    chk("mismatch_ack_addr", ack, 1);
    chk("mismatch_busy", busy, 0);
    write_byte(8'h10, ack);
    chk("mismatch_ack_ptr", ack, 1);
    write_byte(8'h55, ack);
    chk("mismatch_ack_data", ack, 1);
    bus_stop();
    check_wq("mismatch");
    txq = '{8'h77};
    write_txn(8'h30, "after_mismatch");

    // pointer wrap
    txq = '{8'h11, 8'h22};
    write_txn(8'hFF, "wrap");

    // reset while the address ACK of a read holds SDA low
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h20, ack);
    bus_start();
    send_bits(8'hA1, 8);
    chk("rst_pre_sda_low", sda_bus, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_sda_release", sda_bus, 1);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_outputs", {wdata, wstb, rstb, busy}, 11'h000);
    scl = 1'b1;
    half();
    scl = 1'b0;
    qtr();
    rst_n = 1'b1;
    all_high = 1'b1;
    for (int i = 0; i < 9; i++) begin
      clk_bit(1'b1, s);
      all_high = all_high & s;
    end
    chk("rst_ignores_transfer", all_high, 1);
    chk("rst_busy_after", busy, 0);
    bus_stop();
    check_rq("rst");
    txq = '{8'h5A, 8'hC3};
    write_txn(8'h10, "write_after_rst");

    // early STOP mid data byte
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h40, ack);
    chk("early_ack_ptr", ack, 0);
    send_bits(8'hB0, 4);
    bus_stop();
    chk("early_busy", busy, 0);
    chk("early_ptr", reg_addr, 8'h40);
    check_wq("early");

    // randomized write/readback against the reference memory
    for (int k = 0; k < 4; k++) begin
      ptr = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) txq.push_back(8'($urandom));
      write_txn(ptr, "rand_wr");
      read_txn(ptr, n, "rand_rd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
